// File: rtl/ifu_fetch_ctrl_if.sv
// rtl/ifu_fetch_ctrl_if.sv - fetch controller bus bundle (imem request/response, redirect, decode handoff)
// master: fetch controller side. Drives imem_req_valid/imem_req_addr, inst_valid/inst/pc, halted.
// slave : memory + decode + execute side. Drives imem_req_ready, imem_resp_valid/imem_resp_data,
//         redirect_valid/redirect_pc, inst_ready.
interface ifu_fetch_ctrl_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        halted;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst, pc, halted,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst, pc, halted,
      output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - instruction fetch controller, one outstanding imem request
// Ports:
//   clk  - system clock, all state on rising edge
//   rst  - asynchronous active-low reset
//   bus  - ifu_fetch_ctrl_if.master: imem request/response channels, execute redirect,
//          decode handoff (inst_valid/inst_ready/inst/pc) and halted status
module ifu_fetch_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h8000_0000,
   parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
   input  logic               clk,
   input  logic               rst,
   ifu_fetch_ctrl_if.master   bus
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;

   state_t      state;
   logic [31:0] fpc;
   logic        drop;
   logic        req_valid_q;
   logic        inst_valid_q;
   logic        halted_q;
   logic [31:0] inst_q;
   logic [31:0] pc_q;

   logic [31:0] redir_target;
   logic        req_fire;

   assign redir_target = {bus.redirect_pc[31:2], 2'b00};
   assign req_fire     = req_valid_q & bus.imem_req_ready;

   assign bus.imem_req_valid = req_valid_q;
   assign bus.imem_req_addr  = fpc;
   assign bus.inst_valid     = inst_valid_q;
   assign bus.inst           = inst_q;
   assign bus.pc             = pc_q;
   assign bus.halted         = halted_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         fpc          <= RESET_PC;
         drop         <= 1'b0;
         req_valid_q  <= 1'b0;
         inst_valid_q <= 1'b0;
         halted_q     <= 1'b0;
         inst_q       <= 32'h0;
         pc_q         <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.redirect_valid) fpc <= redir_target;
               req_valid_q <= 1'b1;
               state       <= REQ;
            end
            REQ: begin
               if (bus.redirect_valid) fpc <= redir_target;
               if (req_fire) begin
                  // An accepted request that races a redirect is still owed a
                  // response by memory; mark it so it gets thrown away.
                  drop        <= bus.redirect_valid;
                  req_valid_q <= 1'b0;
                  state       <= WAIT;
               end else begin
                  // A redirect without handshake withdraws the request for one
                  // cycle so the new address appears cleanly on the next cycle.
                  req_valid_q <= !bus.redirect_valid;
               end
            end
            WAIT: begin
               if (bus.redirect_valid) begin
                  fpc <= redir_target;
                  if (bus.imem_resp_valid) begin
                     drop        <= 1'b0;
                     req_valid_q <= 1'b1;
                     state       <= REQ;
                  end else begin
                     drop <= 1'b1;
                  end
               end else if (bus.imem_resp_valid) begin
                  if (drop) begin
                     // fpc already holds the redirect target.
                     drop        <= 1'b0;
                     req_valid_q <= 1'b1;
                     state       <= REQ;
                  end else begin
                     inst_q       <= bus.imem_resp_data;
                     pc_q         <= fpc;
                     fpc          <= fpc + 32'd4;
                     inst_valid_q <= 1'b1;
                     state        <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (bus.redirect_valid) begin
                  // Redirect wins over a same-cycle inst_ready: the held
                  // instruction is on the wrong path and is never delivered.
                  fpc          <= redir_target;
                  inst_valid_q <= 1'b0;
                  req_valid_q  <= 1'b1;
                  state        <= REQ;
               end else if (bus.inst_ready) begin
                  inst_valid_q <= 1'b0;
                  if (inst_q == EBREAK_INST) begin
                     halted_q <= 1'b1;
                     state    <= HALT;
                  end else begin
                     req_valid_q <= 1'b1;
                     state       <= REQ;
                  end
               end
            end
            HALT: begin
               req_valid_q  <= 1'b0;
               inst_valid_q <= 1'b0;
               halted_q     <= 1'b1;
            end
            default: begin
               req_valid_q  <= 1'b0;
               inst_valid_q <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule
